// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: opcodes, FSM states and
// datapath mux selects, plus the immediate-format decode used by the controller.
package riscv_ctrl_pkg;

  typedef enum logic [6:0] {
    OpLoad   = 7'b0000011,
    OpStore  = 7'b0100011,
    OpR      = 7'b0110011,
    OpI      = 7'b0010011,
    OpBranch = 7'b1100011,
    OpJal    = 7'b1101111,
    OpJalr   = 7'b1100111,
    OpLui    = 7'b0110111,
    OpAuipc  = 7'b0010111
  } opcode_e;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
    StAluWb, StBranch, StJalr, StJal, StLui, StAuipc, StFault
  } state_e;

  typedef enum logic [2:0] {ImmI = 3'b000, ImmS, ImmB, ImmJ, ImmU} imm_src_e;
  typedef enum logic [1:0] {SrcAPc = 2'b00, SrcAOldPc, SrcARs1, SrcAZero} alu_src_a_e;
  typedef enum logic [1:0] {SrcBRs2 = 2'b00, SrcBImm, SrcBFour} alu_src_b_e;
  // ResAluOut is the registered ALU result, ResAluResult the live ALU output.
  typedef enum logic [1:0] {ResAluOut = 2'b00, ResData, ResAluResult} result_src_e;
  typedef enum logic [1:0] {AluAdd = 2'b00, AluSub, AluFunct} alu_op_e;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  function automatic imm_src_e imm_src_of(logic [6:0] op);
    case (op)
      OpStore:        return ImmS;
      OpBranch:       return ImmB;
      OpJal:          return ImmJ;
      OpLui, OpAuipc: return ImmU;
      default:        return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from funct3 and the ALU comparison flags.
module branch_cond
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3Beq:   taken_o = zero_i;
      F3Bne:   taken_o = ~zero_i;
      F3Blt:   taken_o = lt_i;
      F3Bge:   taken_o = ~lt_i;
      F3Bltu:  taken_o = ltu_i;
      F3Bgeu:  taken_o = ~ltu_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller: FSM sequencing fetch/decode/execute with memory
// wait timeout, sticky fault state and per-instruction retire pulse.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter bit          ENABLE_U    = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       AdrSrc_o,
  output logic       MemReq_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegWrite_o,
  output logic       retire_o,
  output logic       illegal_o,
  output logic       timeout_o,
  output logic [1:0] ResultSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic [2:0] ImmSrc_o,
  output logic [3:0] state_o
);

  localparam int unsigned CntW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            illegal_q, illegal_d, timeout_q, timeout_d, post_rst_q;
  logic            pc_write, ir_write, reg_write, mem_write, retire;
  logic            wait_st, mem_rdy, expire, br_taken, br_illegal;

  branch_cond u_branch_cond (
    .funct3_i  (funct3_i),
    .zero_i    (zero_i),
    .lt_i      (lt_i),
    .ltu_i     (ltu_i),
    .taken_o   (br_taken),
    .illegal_o (br_illegal)
  );

  // The first cycle after reset ignores mem_ready so no strobe can fire in it.
  assign wait_st = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
  assign mem_rdy = mem_ready_i & ~post_rst_q;
  assign expire  = wait_st & ~mem_rdy & ~post_rst_q & (cnt_q == CntLast);
  assign cnt_d   = (!wait_st || mem_rdy || post_rst_q) ? '0 : cnt_q + CntW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StFetch;
      cnt_q      <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
      post_rst_q <= 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    retire      = 1'b0;
    MemReq_o    = 1'b0;
    AdrSrc_o    = 1'b0;
    ALUSrcA_o   = SrcAPc;
    ALUSrcB_o   = SrcBRs2;
    ALUOp_o     = AluAdd;
    ResultSrc_o = ResAluOut;
    unique case (state_q)
      StFetch: begin
        MemReq_o    = 1'b1;
        ALUSrcB_o   = SrcBFour;
        ResultSrc_o = ResAluResult;
        if (mem_rdy) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = StFault;
        end
      end
      StDecode: begin
        ALUSrcA_o = SrcAOldPc;
        ALUSrcB_o = SrcBImm;
        case (opcode_i)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = ENABLE_U ? StLui : StFault;
          OpAuipc:         state_d = ENABLE_U ? StAuipc : StFault;
          default:         state_d = StFault;
        endcase
        if (state_d == StFault) illegal_d = 1'b1;
      end
      StMemAdr: begin
        ALUSrcA_o = SrcARs1;
        ALUSrcB_o = SrcBImm;
        state_d   = (opcode_i == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        MemReq_o = 1'b1;
        AdrSrc_o = 1'b1;
        if (mem_rdy) begin
          state_d = StMemWb;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = StFault;
        end
      end
      StMemWb: begin
        ResultSrc_o = ResData;
        reg_write   = 1'b1;
        retire      = 1'b1;
        state_d     = StFetch;
      end
      StMemWrite: begin
        MemReq_o  = 1'b1;
        AdrSrc_o  = 1'b1;
        mem_write = ~expire;
        if (mem_rdy) begin
          retire  = 1'b1;
          state_d = StFetch;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = StFault;
        end
      end
      StExecR: begin
        ALUSrcA_o = SrcARs1;
        ALUOp_o   = AluFunct;
        state_d   = StAluWb;
      end
      StExecI: begin
        ALUSrcA_o = SrcARs1;
        ALUSrcB_o = SrcBImm;
        ALUOp_o   = AluFunct;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        ALUSrcA_o = SrcARs1;
        ALUOp_o   = AluSub;
        if (br_illegal) begin
          illegal_d = 1'b1;
          state_d   = StFault;
        end else begin
          pc_write = br_taken;
          retire   = 1'b1;
          state_d  = StFetch;
        end
      end
      StJalr: begin
        ALUSrcA_o = SrcARs1;
        ALUSrcB_o = SrcBImm;
        state_d   = StJal;
      end
      StJal: begin
        ALUSrcA_o = SrcAOldPc;
        ALUSrcB_o = SrcBFour;
        pc_write  = 1'b1;
        state_d   = StAluWb;
      end
      StLui: begin
        ALUSrcA_o = SrcAZero;
        ALUSrcB_o = SrcBImm;
        state_d   = StAluWb;
      end
      StAuipc: begin
        ALUSrcA_o = SrcAOldPc;
        ALUSrcB_o = SrcBImm;
        state_d   = StAluWb;
      end
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  assign PCWrite_o  = pc_write & ~rst_i & ~post_rst_q;
  assign IRWrite_o  = ir_write & ~rst_i & ~post_rst_q;
  assign RegWrite_o = reg_write & ~rst_i & ~post_rst_q;
  assign MemWrite_o = mem_write & ~rst_i & ~post_rst_q;
  assign retire_o   = retire & ~rst_i & ~post_rst_q;
  assign illegal_o  = illegal_q;
  assign timeout_o  = timeout_q;
  assign ImmSrc_o   = imm_src_of(opcode_i);
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: per-instruction state traces and
// strobe totals from an instruction-level model, plus directed fault/timeout/reset cases.
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;

  localparam int unsigned TimeoutCyc = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
  logic [6:0] cur_op = 7'd0;
  logic [2:0] cur_f3 = 3'd0;
  logic       cur_z = 1'b0, cur_lt = 1'b0, cur_ltu = 1'b0;

  logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, retire, illegal;
  logic       timeout;
  logic [1:0] result_src, src_a, src_b, alu_op;
  logic [2:0] imm_src;
  logic [3:0] state;
  logic       b_pc_write, b_adr_src, b_mem_req, b_mem_write, b_ir_write, b_reg_write;
  logic       b_retire, b_illegal, b_timeout;
  logic [1:0] b_result_src, b_src_a, b_src_b, b_alu_op;
  logic [2:0] b_imm_src;
  logic [3:0] b_state;

  int unsigned n_checks = 0;
  int unsigned n_errs = 0;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT_CYC(TimeoutCyc), .ENABLE_U(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct3_i(funct3), .zero_i(zero),
    .lt_i(lt), .ltu_i(ltu), .mem_ready_i(mem_ready), .PCWrite_o(pc_write),
    .AdrSrc_o(adr_src), .MemReq_o(mem_req), .MemWrite_o(mem_write), .IRWrite_o(ir_write),
    .RegWrite_o(reg_write), .retire_o(retire), .illegal_o(illegal), .timeout_o(timeout),
    .ResultSrc_o(result_src), .ALUSrcA_o(src_a), .ALUSrcB_o(src_b), .ALUOp_o(alu_op),
    .ImmSrc_o(imm_src), .state_o(state)
  );

  multicycle_control #(.TIMEOUT_CYC(TimeoutCyc), .ENABLE_U(1'b0)) u_dut_nou (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct3_i(funct3), .zero_i(zero),
    .lt_i(lt), .ltu_i(ltu), .mem_ready_i(mem_ready), .PCWrite_o(b_pc_write),
    .AdrSrc_o(b_adr_src), .MemReq_o(b_mem_req), .MemWrite_o(b_mem_write),
    .IRWrite_o(b_ir_write), .RegWrite_o(b_reg_write), .retire_o(b_retire),
    .illegal_o(b_illegal), .timeout_o(b_timeout), .ResultSrc_o(b_result_src),
    .ALUSrcA_o(b_src_a), .ALUSrcB_o(b_src_b), .ALUOp_o(b_alu_op), .ImmSrc_o(b_imm_src),
    .state_o(b_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  // {MemReq, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc} expected in each state.
  function automatic logic [9:0] exp_ctrl(input state_e s);
    case (s)
      StFetch:    return 10'b1_0_00_10_00_10;
      StDecode:   return 10'b0_0_01_01_00_00;
      StMemAdr:   return 10'b0_0_10_01_00_00;
      StMemRead:  return 10'b1_1_00_00_00_00;
      StMemWb:    return 10'b0_0_00_00_00_01;
      StMemWrite: return 10'b1_1_00_00_00_00;
      StExecR:    return 10'b0_0_10_00_10_00;
      StExecI:    return 10'b0_0_10_01_10_00;
      StBranch:   return 10'b0_0_10_00_01_00;
      StJalr:     return 10'b0_0_10_01_00_00;
      StJal:      return 10'b0_0_01_10_00_00;
      StLui:      return 10'b0_0_11_01_00_00;
      StAuipc:    return 10'b0_0_01_01_00_00;
      default:    return 10'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    case (op)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic z, input logic l,
                                    input logic lu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return l;
      3'b101:  return !l;
      3'b110:  return lu;
      default: return !lu;
    endcase
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic step(input logic rdy);
    @(negedge clk);
    opcode = cur_op; funct3 = cur_f3; zero = cur_z; lt = cur_lt; ltu = cur_ltu;
    mem_ready = rdy;
    #1;
  endtask

  function automatic logic [9:0] obs_ctrl();
    return {mem_req, adr_src, src_a, src_b, alu_op, result_src};
  endfunction

  task automatic check_no_strobes(input string tag);
    check(tag, {27'd0, pc_write, ir_write, reg_write, mem_write, retire}, 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'($urandom_range(0, 1));
      #1;
      check_no_strobes("strobes_in_reset");
    end
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    check("post_rst_state", state, StFetch);
    check_no_strobes("post_rst_strobes");
    check("post_rst_flags", {illegal, timeout}, 2'b00);
    check("nou_post_rst", {b_state, b_illegal, b_timeout}, {StFetch, 2'b00});
  endtask

  // Executes one legal instruction with given fetch/memory wait counts and checks the
  // cycle-by-cycle state trace and the strobe totals for the instruction.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int wf,
                           input int wm);
    state_e st[$];
    logic   rd[$];
    int     pcw, irw, rgw, mw, ret, e_pcw, e_rgw, e_mw;
    logic   tk;
    cur_op = op; cur_f3 = f3;
    cur_z = 1'($urandom_range(0, 1)); cur_lt = 1'($urandom_range(0, 1));
    cur_ltu = 1'($urandom_range(0, 1));
    tk = taken_of(f3, cur_z, cur_lt, cur_ltu);
    for (int i = 0; i < wf; i++) begin st.push_back(StFetch); rd.push_back(1'b0); end
    st.push_back(StFetch); rd.push_back(1'b1);
    st.push_back(StDecode); rd.push_back(1'($urandom_range(0, 1)));
    e_pcw = 1; e_rgw = 1; e_mw = 0;
    case (op)
      OpLoad: begin
        st.push_back(StMemAdr); rd.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < wm; i++) begin st.push_back(StMemRead); rd.push_back(1'b0); end
        st.push_back(StMemRead); rd.push_back(1'b1);
        st.push_back(StMemWb); rd.push_back(1'($urandom_range(0, 1)));
      end
      OpStore: begin
        st.push_back(StMemAdr); rd.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < wm; i++) begin st.push_back(StMemWrite); rd.push_back(1'b0); end
        st.push_back(StMemWrite); rd.push_back(1'b1);
        e_rgw = 0; e_mw = wm + 1;
      end
      OpBranch: begin
        st.push_back(StBranch); rd.push_back(1'($urandom_range(0, 1)));
        e_rgw = 0; e_pcw = tk ? 2 : 1;
      end
      default: begin
        case (op)
          OpR:     st.push_back(StExecR);
          OpI:     st.push_back(StExecI);
          OpLui:   st.push_back(StLui);
          OpAuipc: st.push_back(StAuipc);
          OpJalr:  begin st.push_back(StJalr); rd.push_back(1'b1); st.push_back(StJal); end
          default: st.push_back(StJal);
        endcase
        if (op == OpJal || op == OpJalr) e_pcw = 2;
        rd.push_back(1'($urandom_range(0, 1)));
        st.push_back(StAluWb); rd.push_back(1'($urandom_range(0, 1)));
      end
    endcase
    pcw = 0; irw = 0; rgw = 0; mw = 0; ret = 0;
    for (int i = 0; i < st.size(); i++) begin
      step(rd[i]);
      check("state", state, st[i]);
      check("ctrl", obs_ctrl(), exp_ctrl(st[i]));
      check("imm_src", imm_src, exp_imm(op));
      check("mw_without_req", mem_write & ~mem_req, 0);
      pcw += pc_write; irw += ir_write; rgw += reg_write; mw += mem_write; ret += retire;
    end
    check("pcwrite_cnt", pcw, e_pcw);
    check("irwrite_cnt", irw, 1);
    check("regwrite_cnt", rgw, e_rgw);
    check("memwrite_cnt", mw, e_mw);
    check("retire_cnt", ret, 1);
  endtask

  task automatic expect_fault(input logic ill, input logic tmo, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step(1'($urandom_range(0, 1)));
      check("fault_state", state, StFault);
      check("fault_flags", {illegal, timeout}, {ill, tmo});
      check_no_strobes("fault_strobes");
      check("fault_memreq", mem_req, 0);
    end
  endtask

  opcode_e legal_ops[9] = '{OpLoad, OpStore, OpR, OpI, OpBranch, OpJal, OpJalr, OpLui,
                            OpAuipc};
  logic [2:0] br_f3[6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

  initial begin
    do_reset(2);
    // ADD, LW with 3-cycle memory stall, BNE taken and not taken.
    run_instr(OpR, 3'b000, 0, 0);
    run_instr(OpLoad, 3'b010, 0, 3);
    cur_op = OpBranch; cur_f3 = 3'b001;
    step(1'b1); step(1'b0);
    cur_z = 1'b0; step(1'b0);
    check("bne_taken", {state, pc_write}, {StBranch, 1'b1});
    step(1'b1); step(1'b0);
    cur_z = 1'b1; step(1'b0);
    check("bne_not_taken", {state, pc_write, retire}, {StBranch, 1'b0, 1'b1});
    // Reserved branch funct3 faults without writing the PC.
    cur_f3 = 3'b010;
    step(1'b1); step(1'b0); step(1'b0);
    check("bad_branch", {state, pc_write, retire}, {StBranch, 1'b0, 1'b0});
    expect_fault(1'b1, 1'b0, 3);
    do_reset(1);
    // Fetch never completes: 4 wait cycles then timeout fault.
    cur_op = OpR;
    for (int i = 0; i < int'(TimeoutCyc); i++) begin
      step(1'b0);
      check("to_fetch", {state, ir_write}, {StFetch, 1'b0});
    end
    expect_fault(1'b0, 1'b1, 3);
    do_reset(1);
    // Unknown opcode.
    cur_op = 7'b1111111;
    step(1'b1); step(1'b1);
    check("bad_op_decode", state, StDecode);
    expect_fault(1'b1, 1'b0, 2);
    do_reset(1);
    // LUI: legal on the main instance, illegal with U-type disabled.
    run_instr(OpLui, 3'b000, 1, 0);
    check("nou_lui", {b_state, b_illegal}, {StFault, 1'b1});
    do_reset(1);
    run_instr(OpAuipc, 3'b000, 0, 0);
    // Reset in the middle of a store wait.
    cur_op = OpStore;
    step(1'b1); step(1'b0); step(1'b0); step(1'b0);
    check("st_wait", {state, mem_write, mem_req}, {StMemWrite, 1'b1, 1'b1});
    step(1'b0);
    do_reset(1);
    check("st_rst_memwrite", mem_write, 0);
    // Store timeout drops MemWrite on the expiring cycle.
    cur_op = OpStore;
    step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < int'(TimeoutCyc); i++) begin
      step(1'b0);
      check("st_to_memwrite", mem_write, (i == int'(TimeoutCyc) - 1) ? 0 : 1);
    end
    expect_fault(1'b0, 1'b1, 2);
    do_reset(1);
    // Random legal instruction stream.
    for (int n = 0; n < 150; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      op = legal_ops[$urandom_range(0, 8)];
      f3 = (op == OpBranch) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      run_instr(op, f3, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: maximum cycles any state waits on mem_ready_i before faulting.
REQ-002 SHALL have parameter ENABLE_U, default 1: 1 = LUI/AUIPC legal, 0 = both treated as illegal opcodes.
REQ-003 SHALL have ports clk_i in 1 (system clock) and rst_i in 1 (reset: synchronous, active-high).
REQ-004 SHALL have inputs: opcode_i 7 and funct3_i 3 (from instruction register); zero_i 1, lt_i 1, ltu_i 1 (ALU flags); mem_ready_i 1 (memory completes access this cycle).
REQ-005 SHALL have 1-bit outputs PCWrite_o, AdrSrc_o, MemReq_o, MemWrite_o, IRWrite_o, RegWrite_o, retire_o, illegal_o, timeout_o.
REQ-006 SHALL have outputs ResultSrc_o 2, ALUSrcA_o 2, ALUSrcB_o 2, ALUOp_o 2, ImmSrc_o 3, state_o 4 (debug).

Function
REQ-007 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JALR, JAL, LUI, AUIPC, FAULT; state_o = encoding.
REQ-008 FETCH: MemReq=1, AdrSrc=0, SrcA=00 (PC), SrcB=10 (4), ALUOp=00, ResultSrc=10; stay until mem_ready_i; on ready cycle IRWrite=1, PCWrite=1, go DECODE.
REQ-009 DECODE: SrcA=01 (OldPC), SrcB=01 (imm), ALUOp=00; next by opcode: load/store->MEMADR, R->EXECR, I-ALU->EXECI, B->BRANCH, JAL->JAL, JALR->JALR, LUI->LUI, AUIPC->AUIPC, else FAULT with illegal_o.
REQ-010 MEMADR: SrcA=10 (rs1), SrcB=01, ALUOp=00; load->MEMREAD, store->MEMWRITE.
REQ-011 MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00; hold until mem_ready_i, then MEMWB; MEMWB: ResultSrc=01, RegWrite=1, ->FETCH.
REQ-012 MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00; hold until mem_ready_i, then FETCH.
REQ-013 EXECR: SrcA=10, SrcB=00, ALUOp=10; EXECI: SrcA=10, SrcB=01, ALUOp=10; both ->ALUWB; ALUWB: ResultSrc=00, RegWrite=1, ->FETCH.
REQ-014 BRANCH: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00; PCWrite = taken, funct3 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; ->FETCH; funct3 010/011 -> FAULT with illegal_o, PCWrite=0.
REQ-015 JALR: SrcA=10, SrcB=01, ALUOp=00, ->JAL; JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, ->ALUWB.
REQ-016 LUI: SrcA=11 (zero), SrcB=01, ALUOp=00; AUIPC: SrcA=01, SrcB=01, ALUOp=00; both ->ALUWB.
REQ-017 ImmSrc_o combinational from opcode_i in every state: I/load/JALR 000, S 001, B 010, J 011, U 100, other 000.
REQ-018 Unlisted outputs SHALL be 0 in each state; MemWrite_o never asserted without MemReq_o.
REQ-019 retire_o SHALL pulse exactly one cycle per instruction: MEMWB, ALUWB, BRANCH, or MEMWRITE on its ready cycle.
REQ-020 Wait counter (width clog2(TIMEOUT_CYC+1)) SHALL clear on entry to FETCH/MEMREAD/MEMWRITE and on mem_ready_i, increment each non-ready wait cycle; reaching TIMEOUT_CYC -> FAULT with timeout_o, no write strobes that cycle.
REQ-021 mem_ready_i SHALL be ignored outside FETCH/MEMREAD/MEMWRITE.
REQ-022 FAULT SHALL be sticky until reset; all strobes 0; illegal_o/timeout_o held.

Reset
REQ-023 rst_i high at a clock edge SHALL force FETCH, clear counter, illegal_o, timeout_o, in any state including mid-wait.
REQ-024 During and the cycle after reset, all write strobes (PCWrite, IRWrite, RegWrite, MemWrite) SHALL be 0.

Structure
REQ-025 Opcode enum, state enum, ImmSrc/ALUSrc/ResultSrc/ALUOp encodings SHALL live in shared package riscv_ctrl_pkg.
REQ-026 Branch condition evaluation SHALL be sub-module branch_cond (funct3, flags -> taken, illegal).

Verification
REQ-027 ADD (0110011), ready same cycle -> FETCH,DECODE,EXECR,ALUWB; RegWrite one cycle; retire_o once; 4 cycles.
REQ-028 LW with mem_ready_i low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, MemReq=1 throughout, then MEMWB RegWrite=1.
REQ-029 BNE funct3=001, zero_i=0 -> PCWrite=1 in BRANCH; zero_i=1 -> PCWrite=0; funct3=010 -> FAULT, illegal_o=1.
REQ-030 mem_ready_i stuck low in FETCH, TIMEOUT_CYC=4 -> FAULT after 4 wait cycles, timeout_o=1, IRWrite never 1.
REQ-031 ENABLE_U=0, opcode 0110111 -> FAULT, illegal_o=1; rst_i pulse -> FETCH, flags 0.
REQ-032 rst_i asserted during MEMWRITE wait -> next cycle FETCH, MemWrite_o=0.
